// File: rtl/det_patgen_pkg.sv
// Pattern selection, march-element tables and LFSR constants for the BIST pattern generator.
package bist_pattern_sel;

   typedef enum logic [1:0] {
      PAT_ZERO_ONE     = 2'd0,
      PAT_CHECKERBOARD = 2'd1,
      PAT_MARCH_CM     = 2'd2,
      PAT_LFSR         = 2'd3
   } bist_pattern_sel_t;

   typedef enum logic [1:0] {
      OP_R0 = 2'd0,
      OP_R1 = 2'd1,
      OP_W0 = 2'd2,
      OP_W1 = 2'd3
   } march_op_t;

   typedef enum logic [1:0] {
      DIR_UP   = 2'd0,
      DIR_DOWN = 2'd1,
      DIR_ANY  = 2'd2
   } march_dir_t;

   typedef struct packed {
      march_dir_t dir;
      logic       two_ops;
      march_op_t  op0;
      march_op_t  op1;
   } march_elem_t;

   localparam int ELEM_IDX_W = 3;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;

   localparam march_elem_t ZERO_ONE_TBL [4] = '{
      '{DIR_UP, 1'b0, OP_W0, OP_W0},
      '{DIR_UP, 1'b0, OP_R0, OP_R0},
      '{DIR_UP, 1'b0, OP_W1, OP_W1},
      '{DIR_UP, 1'b0, OP_R1, OP_R1}
   };

   localparam march_elem_t MARCH_CM_TBL [6] = '{
      '{DIR_UP,   1'b0, OP_W0, OP_W0},
      '{DIR_UP,   1'b1, OP_R0, OP_W1},
      '{DIR_UP,   1'b1, OP_R1, OP_W0},
      '{DIR_DOWN, 1'b1, OP_R0, OP_W1},
      '{DIR_DOWN, 1'b1, OP_R1, OP_W0},
      '{DIR_UP,   1'b0, OP_R0, OP_R0}
   };

   // LFSR data ignores the 0/1 polarity; only the read/write kind matters.
   localparam march_elem_t LFSR_TBL [2] = '{
      '{DIR_UP, 1'b0, OP_W0, OP_W0},
      '{DIR_UP, 1'b0, OP_R0, OP_R0}
   };

   function automatic logic [ELEM_IDX_W-1:0] num_elems(bist_pattern_sel_t p);
      case (p)
         PAT_ZERO_ONE, PAT_CHECKERBOARD: num_elems = 3'd4;
         PAT_MARCH_CM:                   num_elems = 3'd6;
         PAT_LFSR:                       num_elems = 3'd2;
         default:                        num_elems = 3'd0;
      endcase
   endfunction

   function automatic march_elem_t elem_at(bist_pattern_sel_t p, logic [ELEM_IDX_W-1:0] idx);
      elem_at = '{DIR_UP, 1'b0, OP_R0, OP_R0};
      case (p)
         PAT_ZERO_ONE, PAT_CHECKERBOARD: if (idx < 3'd4) elem_at = ZERO_ONE_TBL[idx[1:0]];
         PAT_MARCH_CM:                   if (idx < 3'd6) elem_at = MARCH_CM_TBL[idx];
         PAT_LFSR:                       if (idx < 3'd2) elem_at = LFSR_TBL[idx[0]];
         default:                        elem_at = '{DIR_UP, 1'b0, OP_R0, OP_R0};
      endcase
   endfunction

   function automatic logic [31:0] lfsr_next(logic [31:0] s);
      lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/det_patgen_lfsr.sv
// 32-bit Galois LFSR data source; load returns it to the seed, advance steps it once.
`ifdef PATGEN_LFSR_EN
module patgen_lfsr
   import bist_pattern_sel::*;
(
   input  logic        clk,
   input  logic        rstb,
   input  logic        load,
   input  logic        advance,
   output logic [31:0] q
);

   logic [31:0] q_d, q_q;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = LFSR_SEED;
      end else if (advance) begin
         q_d = lfsr_next(q_q);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         q_q <= LFSR_SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule
`endif

// File: rtl/det_patgen.sv
// SRAM march / background pattern generator driving the BIST op valid/ready interface.
// PATGEN_LFSR_EN adds the PAT_LFSR pattern; without it PAT_LFSR is rejected like an unknown pattern.
module det_patgen
   import bist_pattern_sel::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MUX_RATIO  = 4
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  start,
   input  bist_pattern_sel_t     pattern_sel,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [ADDR_WIDTH-1:0] op_addr,
   output logic                  op_we,
   output logic [DATA_WIDTH-1:0] op_data,
   output logic                  busy,
   output logic                  done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   logic [1:0]            state_d, state_q;
   bist_pattern_sel_t     pat_d, pat_q;
   logic [ELEM_IDX_W-1:0] elem_d, elem_q;
   logic                  op_idx_d, op_idx_q;
   logic [ADDR_WIDTH-1:0] addr_d, addr_q;
   logic                  reject_d, reject_q;

   logic                  run, xfer, elem_end, last_elem, last_op;
   logic [ELEM_IDX_W-1:0] n_elems;
   march_elem_t           cur_elem;
   march_op_t             cur_op;
   logic [DATA_WIDTH-1:0] bg;

   function automatic logic [ELEM_IDX_W-1:0] active_elems(bist_pattern_sel_t p);
`ifdef PATGEN_LFSR_EN
      active_elems = num_elems(p);
`else
      active_elems = (p == PAT_LFSR) ? '0 : num_elems(p);
`endif
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] first_addr(march_elem_t e);
      first_addr = (e.dir == DIR_DOWN) ? LAST_ADDR : '0;
   endfunction

   // Physical checkerboard through the column mux: bit i of word a sits at column i*MUX_RATIO + a%MUX_RATIO.
   function automatic logic [DATA_WIDTH-1:0] ckbd(logic [ADDR_WIDTH-1:0] a);
      ckbd = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         ckbd[i] = 1'((32'(a) / 32'(MUX_RATIO) + 32'(i) * 32'(MUX_RATIO)
                       + 32'(a) % 32'(MUX_RATIO)) & 32'd1);
      end
   endfunction

   assign run       = (state_q == ST_RUN);
   assign xfer      = run & op_ready;
   assign n_elems   = active_elems(pat_q);
   assign cur_elem  = elem_at(pat_q, elem_q);
   assign cur_op    = (op_idx_q && cur_elem.two_ops) ? cur_elem.op1 : cur_elem.op0;
   assign last_op   = !cur_elem.two_ops || op_idx_q;
   assign elem_end  = (cur_elem.dir == DIR_DOWN) ? (addr_q == '0) : (addr_q == LAST_ADDR);
   assign last_elem = (elem_q == n_elems - 1'b1);

   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      elem_d   = elem_q;
      op_idx_d = op_idx_q;
      addr_d   = addr_q;
      reject_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A rejected start spends one idle cycle so done lands two cycles after start.
            if (reject_q) begin
               state_d = ST_DONE;
            end else if (start) begin
               pat_d    = pattern_sel;
               elem_d   = '0;
               op_idx_d = 1'b0;
               addr_d   = first_addr(elem_at(pattern_sel, '0));
               if (active_elems(pattern_sel) != '0) begin
                  state_d = ST_RUN;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (op_ready) begin
               if (!last_op) begin
                  op_idx_d = 1'b1;
               end else begin
                  op_idx_d = 1'b0;
                  if (!elem_end) begin
                     addr_d = (cur_elem.dir == DIR_DOWN) ? addr_q - 1'b1 : addr_q + 1'b1;
                  end else if (last_elem) begin
                     state_d = ST_DONE;
                  end else begin
                     elem_d = elem_q + 1'b1;
                     addr_d = first_addr(elem_at(pat_q, elem_q + 1'b1));
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q  <= ST_IDLE;
         pat_q    <= PAT_ZERO_ONE;
         elem_q   <= '0;
         op_idx_q <= 1'b0;
         addr_q   <= '0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pat_q    <= pat_d;
         elem_q   <= elem_d;
         op_idx_q <= op_idx_d;
         addr_q   <= addr_d;
         reject_q <= reject_d;
      end
   end

`ifdef PATGEN_LFSR_EN
   logic [31:0]           lfsr_q;
   logic [DATA_WIDTH-1:0] lfsr_word;
   logic                  lfsr_load;

   // Reseed on start and again when the write element finishes, so reads replay the stream.
   assign lfsr_load = (state_q == ST_IDLE && start && !reject_q)
                    || (xfer && elem_q == '0 && last_op && elem_end);

   patgen_lfsr u_lfsr (
      .clk     (clk),
      .rstb    (rstb),
      .load    (lfsr_load),
      .advance (xfer),
      .q       (lfsr_q)
   );

   always_comb begin
      lfsr_word = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         lfsr_word[i] = lfsr_q[i % 32];
      end
   end
`endif

   always_comb begin
      bg      = (pat_q == PAT_CHECKERBOARD) ? ckbd(addr_q) : '0;
      op_data = (cur_op == OP_R1 || cur_op == OP_W1) ? ~bg : bg;
`ifdef PATGEN_LFSR_EN
      if (pat_q == PAT_LFSR) begin
         op_data = lfsr_word;
      end
`endif
      if (!run) begin
         op_data = '0;
      end
   end

   assign op_valid = run;
   assign busy     = run;
   assign done     = (state_q == ST_DONE);
   assign op_addr  = run ? addr_q : '0;
   assign op_we    = run & (cur_op == OP_W0 || cur_op == OP_W1);

endmodule

// File: tb/tb_det_patgen.sv
// Directed bench for det_patgen: four configurations behind one observation mux.
module tb_det_patgen;
   import bist_pattern_sel::*;

   localparam int AW_T  [4] = '{3, 5, 4, 1};
   localparam int DEP_T [4] = '{8, 4, 16, 1};
   localparam int DW_T  [4] = '{8, 32, 32, 32};

   logic              clk;
   logic              rstb;
   logic              start;
   logic              op_ready;
   bist_pattern_sel_t pattern_sel;
   logic [1:0]        sel;

   logic [3:0]  vld_w, we_w, busy_w, done_w;
   logic [4:0]  addr_w [4];
   logic [31:0] data_w [4];

   logic        o_vld, o_we, o_busy, o_done;
   logic [4:0]  o_addr;
   logic [31:0] o_data;

   int n_chk, n_pass, n_fail;

   logic [37:0] exp_q [$];
   logic [37:0] obs_q [$];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int AW = AW_T[g];
      localparam int DW = DW_T[g];
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      det_patgen #(
         .ADDR_WIDTH (AW),
         .DEPTH      (DEP_T[g]),
         .DATA_WIDTH (DW),
         .MUX_RATIO  (4)
      ) u_dut (
         .clk         (clk),
         .rstb        (rstb),
         .start       (start && (sel == 2'(g))),
         .pattern_sel (pattern_sel),
         .op_valid    (vld_w[g]),
         .op_ready    (op_ready),
         .op_addr     (a),
         .op_we       (we_w[g]),
         .op_data     (d),
         .busy        (busy_w[g]),
         .done        (done_w[g])
      );
      assign addr_w[g] = 5'(a);
      assign data_w[g] = 32'(d);
   end

   assign o_vld  = vld_w[sel];
   assign o_we   = we_w[sel];
   assign o_busy = busy_w[sel];
   assign o_done = done_w[sel];
   assign o_addr = addr_w[sel];
   assign o_data = data_w[sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dmask(int dw);
      return (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
   endfunction

   function automatic logic [31:0] bg_word(int a, int dw, bit ck);
      logic [31:0] w;
      w = '0;
      if (ck) begin
         for (int i = 0; i < dw; i++) begin
            w[i] = (((a / 4) + i * 4 + (a % 4)) % 2) == 1;
         end
      end
      return w;
   endfunction

   // op codes: 0 = r0, 1 = r1, 2 = w0, 3 = w1
   task automatic add_elem(input int g, input bit down, input int nops,
                           input int op0, input int op1, input bit ck);
      int d, a, op;
      logic [31:0] w;
      d = DEP_T[g];
      for (int k = 0; k < d; k++) begin
         a = down ? (d - 1 - k) : k;
         for (int j = 0; j < nops; j++) begin
            op = (j == 0) ? op0 : op1;
            w  = bg_word(a, DW_T[g], ck);
            if (op % 2 == 1) w = ~w;
            exp_q.push_back({5'(a), 1'(op >= 2), w & dmask(DW_T[g])});
         end
      end
   endtask

   task automatic build_exp(input int g, input bist_pattern_sel_t pat);
      bit ck;
      logic [31:0] s;
      exp_q.delete();
      s  = 32'hACE1_2345;
      ck = (pat == PAT_CHECKERBOARD);
      case (pat)
         PAT_ZERO_ONE, PAT_CHECKERBOARD: begin
            add_elem(g, 0, 1, 2, 2, ck);
            add_elem(g, 0, 1, 0, 0, ck);
            add_elem(g, 0, 1, 3, 3, ck);
            add_elem(g, 0, 1, 1, 1, ck);
         end
         PAT_MARCH_CM: begin
            add_elem(g, 0, 1, 2, 2, 0);
            add_elem(g, 0, 2, 0, 3, 0);
            add_elem(g, 0, 2, 1, 2, 0);
            add_elem(g, 1, 2, 0, 3, 0);
            add_elem(g, 1, 2, 1, 2, 0);
            add_elem(g, 0, 1, 0, 0, 0);
         end
         default: begin
`ifdef PATGEN_LFSR_EN
            for (int pass = 0; pass < 2; pass++) begin
               s = 32'hACE1_2345;
               for (int k = 0; k < DEP_T[g]; k++) begin
                  exp_q.push_back({5'(k), 1'(pass == 0), s & dmask(DW_T[g])});
                  s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
               end
            end
`endif
         end
      endcase
   endtask

   function automatic logic [37:0] obs_at(int i);
      return (i < obs_q.size()) ? obs_q[i] : 38'bx;
   endfunction

   task automatic run_seq(input logic [1:0] g, input bist_pattern_sel_t pat,
                          input bit rnd, input bit poke_start, input string tag);
      int n, cyc, last_x, done_cyc, n_exp;
      bit stalled;
      logic [37:0] cur, prev, expv;
      build_exp(int'(g), pat);
      n_exp = exp_q.size();
      obs_q.delete();
      sel = g;
      pattern_sel = pat;
      op_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_first_valid"}, 64'(o_vld), 64'(n_exp != 0));
      chk({tag, "_busy"}, 64'(o_busy), 64'(n_exp != 0));
      n = 0; cyc = 0; last_x = -1; done_cyc = -1; stalled = 1'b0; prev = '0;
      while (cyc < 2000) begin
         if (o_done) begin
            done_cyc = cyc;
            break;
         end
         cur = {o_addr, o_we, o_data};
         if (stalled) chk($sformatf("%s_stall_hold%0d", tag, cyc), 64'(cur), 64'(prev));
         op_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke_start) begin
            start = (cyc == 5);
            pattern_sel = PAT_ZERO_ONE;
         end
         if (o_vld && op_ready) begin
            expv = (n < n_exp) ? exp_q[n] : 38'bx;
            chk($sformatf("%s_op%0d", tag, n), 64'(cur), 64'(expv));
            obs_q.push_back(cur);
            n++;
            last_x = cyc;
         end
         stalled = o_vld && !op_ready;
         prev = cur;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_op_count"}, 64'(n), 64'(n_exp));
      chk({tag, "_done_cycle"}, 64'(done_cyc), 64'((n_exp != 0) ? last_x + 1 : 1));
      if (!rnd && n_exp != 0) chk({tag, "_no_bubbles"}, 64'(done_cyc), 64'(n_exp));
      @(negedge clk);
      chk({tag, "_idle_after_done"}, 64'({o_done, o_busy, o_vld}), 64'(0));
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0;
      rstb = 1'b0; start = 1'b0; op_ready = 1'b0; sel = 2'd0;
      pattern_sel = PAT_ZERO_ONE;
      repeat (3) @(negedge clk);
      chk("reset_flags_all", 64'({vld_w, we_w, busy_w, done_w}), 64'(0));
      chk("reset_addr_data", 64'({o_addr, o_data}), 64'(0));
      rstb = 1'b1;
      @(negedge clk);

      // Zero/one background, DEPTH=4, 32-bit words
      run_seq(2'd1, PAT_ZERO_ONE, 1'b0, 1'b0, "zero_one");
      chk("zo_w0_a0",  64'(obs_at(0)),  64'({5'd0, 1'b1, 32'h0000_0000}));
      chk("zo_r0_a0",  64'(obs_at(4)),  64'({5'd0, 1'b0, 32'h0000_0000}));
      chk("zo_w1_a3",  64'(obs_at(11)), 64'({5'd3, 1'b1, 32'hFFFF_FFFF}));
      chk("zo_r1_a0",  64'(obs_at(12)), 64'({5'd0, 1'b0, 32'hFFFF_FFFF}));

      // Checkerboard, MUX_RATIO=4, 8-bit words: whole words alternate per column-mux slot
      run_seq(2'd0, PAT_CHECKERBOARD, 1'b0, 1'b0, "ckbd");
      chk("ckbd_w0_a0", 64'(obs_at(0)),  64'({5'd0, 1'b1, 32'h00}));
      chk("ckbd_w0_a1", 64'(obs_at(1)),  64'({5'd1, 1'b1, 32'hFF}));
      chk("ckbd_w0_a4", 64'(obs_at(4)),  64'({5'd4, 1'b1, 32'hFF}));
      chk("ckbd_w0_a5", 64'(obs_at(5)),  64'({5'd5, 1'b1, 32'h00}));
      chk("ckbd_r1_a0", 64'(obs_at(24)), 64'({5'd0, 1'b0, 32'hFF}));
      chk("ckbd_r1_a1", 64'(obs_at(25)), 64'({5'd1, 1'b0, 32'h00}));
      chk("ckbd_r1_a4", 64'(obs_at(28)), 64'({5'd4, 1'b0, 32'h00}));

      // March C-, DEPTH=8
      run_seq(2'd0, PAT_MARCH_CM, 1'b0, 1'b0, "march");
      chk("march_e4_first", 64'(obs_at(40)), 64'({5'd7, 1'b0, 32'h00}));
      chk("march_e4_second", 64'(obs_at(41)), 64'({5'd7, 1'b1, 32'hFF}));
      chk("march_e4_last",  64'(obs_at(55)), 64'({5'd0, 1'b1, 32'hFF}));
      chk("march_e6_first", 64'(obs_at(72)), 64'({5'd0, 1'b0, 32'h00}));
      chk("march_e6_last",  64'(obs_at(79)), 64'({5'd7, 1'b0, 32'h00}));

      // Random backpressure plus a start pulse (other pattern) while running
      run_seq(2'd0, PAT_MARCH_CM, 1'b1, 1'b1, "march_rnd");

      // Reset in the middle of a run
      sel = 2'd0;
      pattern_sel = PAT_MARCH_CM;
      op_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (37) @(negedge clk);
      chk("pre_reset_op37", 64'({o_vld, o_addr, o_we, o_data}), 64'({1'b1, 5'd6, 1'b1, 32'h00}));
      #2 rstb = 1'b0;
      #1;
      chk("reset_abort_flags", 64'({o_vld, o_busy, o_we, o_done}), 64'(0));
      chk("reset_abort_addr_data", 64'({o_addr, o_data}), 64'(0));
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      run_seq(2'd0, PAT_MARCH_CM, 1'b0, 1'b0, "march_restart");
      chk("restart_first_op", 64'(obs_at(0)), 64'({5'd0, 1'b1, 32'h00}));

      // Single-word memory
      run_seq(2'd3, PAT_MARCH_CM, 1'b0, 1'b0, "depth1");
      chk("depth1_e4", 64'(obs_at(5)), 64'({5'd0, 1'b0, 32'h0}));

      // LFSR pattern (or rejection when not built)
      run_seq(2'd2, PAT_LFSR, 1'b0, 1'b0, "lfsr");
`ifdef PATGEN_LFSR_EN
      chk("lfsr_w_first",  64'(obs_at(0)),  64'({5'd0, 1'b1, 32'hACE1_2345}));
      chk("lfsr_w_second", 64'(obs_at(1)),  64'({5'd1, 1'b1, 32'hD650_91A1}));
      chk("lfsr_r_first",  64'(obs_at(16)), 64'({5'd0, 1'b0, 32'hACE1_2345}));
      chk("lfsr_r_second", 64'(obs_at(17)), 64'({5'd1, 1'b0, 32'hD650_91A1}));
`else
      chk("lfsr_no_ops", 64'(obs_q.size()), 64'(0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
